// File: rtl/iter_alu.sv
// Execute-stage ALU with a valid/ready request and result handshake.
// Ports: clk, rst_n, in_valid/in_ready, ctrl_ALU, src_a, src_b,
//   out_valid/out_ready, result, zero, illegal.
// Shifts run one bit per cycle; all other ops complete in one cycle.
module iter_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ctrl_ALU,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            zero_q, zero_d;
    logic            ill_q, ill_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [3:0]      ctrl_q, ctrl_d;

    logic [SHW-1:0]  shamt;
    logic            is_shift;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [XLEN-1:0] step;

    assign shamt    = src_b[SHW-1:0];
    assign is_shift = (ctrl_ALU == OP_SLL) || (ctrl_ALU == OP_SRL) ||
                      (ctrl_ALU == OP_SRA);

    // Single-cycle result; a shift only lands here when shamt is zero,
    // so it passes src_a through unchanged.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        unique case (ctrl_ALU)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                                ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_res = src_a;
            default: alu_ill = 1'b1;
        endcase
    end

    // One-bit shift of the working register (result register reused).
    always_comb begin
        step = res_q;
        case (ctrl_q)
            OP_SLL:  step = {res_q[XLEN-2:0], 1'b0};
            OP_SRL:  step = {1'b0, res_q[XLEN-1:1]};
            default: step = {res_q[XLEN-1], res_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ctrl_d = ctrl_ALU;
                    if (is_shift && (shamt != '0)) begin
                        res_d   = src_a;
                        cnt_d   = shamt;
                        zero_d  = 1'b0;
                        ill_d   = 1'b0;
                        state_d = S_SHIFT;
                    end else begin
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        ill_d   = alu_ill;
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                res_d = step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    zero_d  = (step == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
            ctrl_q  <= OP_ADD;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: fixed vectors, multi-cycle corner sequences
// and random operations against a behavioural model.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ctrl_ALU = 4'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    iter_alu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_ALU(ctrl_ALU), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        il;
        int          lat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural reference using plain operators.
    task automatic model(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r,
                         output logic z, output logic il,
                         output int lat);
        int sh;
        sh  = int'(b % 32);
        r   = 0;
        il  = 0;
        lat = 1;
        case (c)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a << sh;
            4'd3: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd4: r = (a < b) ? 1 : 0;
            4'd5: r = a ^ b;
            4'd6: r = a >> sh;
            4'd7: r = $signed(a) >>> sh;
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: il = 1;
        endcase
        if ((c == 4'd2 || c == 4'd6 || c == 4'd7) && sh != 0)
            lat = sh + 1;
        z = (r == 0);
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge clk); #1;
        ctrl_ALU = c; src_a = a; src_b = b; in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_pop", {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    task automatic run(input string nm, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez,
                       input logic eil, input int elat, input int hold);
        int lat;
        logic [31:0] r0;
        issue(c, a, b);
        wait_valid(lat);
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_lat"}, 32'(lat), 32'(elat));
        check({nm, "_res"}, result, er);
        check({nm, "_zero"}, 32'(zero), 32'(ez));
        check({nm, "_ill"}, 32'(illegal), 32'(eil));
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({nm, "_hold"}, {result[31:2], in_ready, out_valid},
                  {r0[31:2], 1'b0, 1'b1});
        end
        pop();
    endtask

    vec_t vt[$];

    initial begin
        int lat;
        logic [31:0] er;
        logic ez, eil;
        int elat;
        logic [3:0] rc;
        logic [31:0] ra, rb;

        vt.push_back('{"add_wrap", 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1});
        vt.push_back('{"sub", 4'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0, 1});
        vt.push_back('{"slt", 4'd3, 32'h80000000, 32'd1, 32'd1, 1'b0, 1'b0, 1});
        vt.push_back('{"sltu", 4'd4, 32'h80000000, 32'd1, 32'd0, 1'b1, 1'b0, 1});
        vt.push_back('{"sra31", 4'd7, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 32});
        vt.push_back('{"srl31", 4'd6, 32'h80000000, 32'd31, 32'd1, 1'b0, 1'b0, 32});
        vt.push_back('{"sll0", 4'd2, 32'h12345678, 32'h20, 32'h12345678, 1'b0, 1'b0, 1});
        vt.push_back('{"sll3", 4'd2, 32'd1, 32'h23, 32'd8, 1'b0, 1'b0, 4});
        vt.push_back('{"sll_out", 4'd2, 32'h80000000, 32'd1, 32'd0, 1'b1, 1'b0, 2});
        vt.push_back('{"illegal", 4'hD, 32'd5, 32'd6, 32'd0, 1'b1, 1'b1, 1});
        vt.push_back('{"and", 4'd9, 32'hC, 32'hA, 32'h8, 1'b0, 1'b0, 1});
        vt.push_back('{"or", 4'd8, 32'hF000000F, 32'h0F0, 32'hF00000FF, 1'b0, 1'b0, 1});

        #12;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_outs", {result[29:0], zero, illegal}, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a 20-bit shift.
        issue(4'd2, 32'd1, 32'd20);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_res", result, 32'd0);
        #3 rst_n = 1'b1;
        run("post_rst_add", 4'd0, 32'd7, 32'd9, 32'd16, 1'b0, 1'b0, 1, 0);

        foreach (vt[i])
            run(vt[i].name, vt[i].c, vt[i].a, vt[i].b, vt[i].r,
                vt[i].z, vt[i].il, vt[i].lat, 0);

        // Backpressure with a pending request held by the requester.
        issue(4'd5, 32'hF0F0, 32'h0FF0);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd1);
        check("bp_res", result, 32'hFF00);
        ctrl_ALU = 4'd9; src_a = 32'hC; src_b = 32'hA; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {result[31:2], in_ready, out_valid},
                  {30'h3FC0, 1'b0, 1'b1});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_not_yet", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_res", result, 32'h8);
        pop();

        // Random operations against the model.
        for (int k = 0; k < 150; k++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (k % 4 == 0) ra = 32'h80000000 | (ra >> 8);
            model(rc, ra, rb, er, ez, eil, elat);
            run("rand", rc, ra, rb, er, ez, eil, elat,
                int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
